// File: rtl/serv_rdata_ser_pkg.sv
// Shared constants and types for the SERV load-data serializer.
package serv_rdata_ser_pkg;

  localparam int STREAM_LEN = 32;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUS   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  typedef struct packed {
    logic [1:0] lsb;
    logic [1:0] size;
    logic       sgn;
  } load_cfg_t;

endpackage

// File: rtl/serv_rdata_align.sv
// Combinational alignment of the read word: byte-offset shift, extension bit
// select and the per-size bit-limit compare used while streaming.
module serv_rdata_align
  import serv_rdata_ser_pkg::*;
(
  input  logic [31:0] rdt,
  input  load_cfg_t   cfg,
  input  logic [4:0]  cnt,
  output logic [31:0] shifted,
  output logic        sign,
  output logic        in_range
);

  always_comb begin
    shifted  = rdt >> {cfg.lsb, 3'b000};
    sign     = 1'b0;
    in_range = 1'b1;
    // Size 11 falls into the default branch and behaves as a word.
    case (cfg.size)
      SIZE_BYTE: begin
        sign     = cfg.sgn & shifted[7];
        in_range = (cnt < 5'd8);
      end
      SIZE_HALF: begin
        sign     = cfg.sgn & shifted[15];
        in_range = (cnt < 5'd16);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serv_rdata_ser.sv
// Load-data path: bus read, capture and align, then LSB-first serial stream.
//   state    | meaning
//   ST_IDLE  | waiting for i_req
//   ST_BUS   | o_dbus_cyc high, waiting for i_dbus_ack
//   ST_SHIFT | aligned word held, one bit consumed per i_en
module serv_rdata_ser
  import serv_rdata_ser_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [1:0]  i_lsb,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic        o_dbus_cyc,
  input  logic        i_dbus_ack,
  input  logic [31:0] i_dbus_rdt,
  output logic        o_rdy,
  input  logic        i_en,
  output logic        o_q,
  output logic        o_done
);

  logic [1:0]  state;
  load_cfg_t   cfg;
  logic [31:0] data;
  logic [4:0]  cnt;
  logic        sign;
  logic        done;

  logic [31:0] shifted;
  logic        al_sign;
  logic        in_range;

  serv_rdata_align u_align (
    .rdt      (i_dbus_rdt),
    .cfg      (cfg),
    .cnt      (cnt),
    .shifted  (shifted),
    .sign     (al_sign),
    .in_range (in_range)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      cfg   <= '0;
      data  <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            cfg   <= '{lsb: i_lsb, size: i_size, sgn: i_signed};
            state <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (i_dbus_ack) begin
            data  <= shifted;
            sign  <= al_sign;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (i_en) begin
            data <= {1'b0, data[31:1]};
            cnt  <= cnt + 5'd1;
            // Counter wraps to zero on the last bit; the stream ends here.
            if (cnt == 5'(STREAM_LEN - 1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_dbus_cyc = (state == ST_BUS);
  assign o_rdy      = (state == ST_SHIFT);
  assign o_q        = o_rdy & (in_range ? data[0] : sign);
  assign o_done     = done;

endmodule

// File: tb/tb_serv_rdata_ser.sv
// Self-checking bench for serv_rdata_ser: expected load results queued at
// request time, compared against the reassembled serial stream.
module tb_serv_rdata_ser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  lsb = 2'd0;
  logic [1:0]  size = 2'd0;
  logic        sgn = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rdt = 32'h0;
  logic        en = 1'b0;
  logic        cyc, rdy, q, done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  serv_rdata_ser dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_lsb      (lsb),
    .i_size     (size),
    .i_signed   (sgn),
    .o_dbus_cyc (cyc),
    .i_dbus_ack (ack),
    .i_dbus_rdt (rdt),
    .o_rdy      (rdy),
    .i_en       (en),
    .o_q        (q),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] r, input logic [1:0] l,
                                        input logic [1:0] s, input logic g);
    logic [31:0] sh;
    sh = r >> (int'(l) * 8);
    case (s)
      2'd0:    return g ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      2'd1:    return g ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Drives one load and collects its stream; flags describe handshake health.
  task automatic run_load(input logic [31:0] r, input logic [1:0] l, input logic [1:0] s,
                          input logic g, input int wait_cyc, input bit rand_en,
                          input bit spurious, output logic [31:0] word,
                          output logic [4:0] flags);
    bit cyc_ok, rdy_ok, done_ok, early, tmo;
    int n, budget;
    cyc_ok = 1; rdy_ok = 1; done_ok = 1; early = 0; tmo = 0; word = '0;
    sb.push_back(model(r, l, s, g));
    req = 1; lsb = l; size = s; sgn = g;
    ack = spurious; rdt = spurious ? 32'h0BAD0BAD : 32'h0;
    @(posedge clk); #1;
    req = 0; ack = 0;
    if (cyc !== 1'b1) cyc_ok = 0;
    for (int w = 0; w < wait_cyc; w++) begin
      if (spurious && w == 2) begin
        req = 1; lsb = ~l; size = 2'd0; sgn = ~g;
      end else req = 0;
      @(posedge clk); #1;
      if (cyc !== 1'b1 || rdy !== 1'b0) cyc_ok = 0;
    end
    req = 0; ack = 1; rdt = r;
    @(posedge clk); #1;
    ack = 0; rdt = 32'hA5A5A5A5;
    if (cyc !== 1'b0 || rdy !== 1'b1) rdy_ok = 0;
    n = 0; budget = 0;
    while (n < 32 && budget < 500) begin
      en  = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      req = spurious && (n == 5);
      if (done !== 1'b0) early = 1;
      if (rdy !== 1'b1) rdy_ok = 0;
      if (en) begin
        word[n] = q;
        n++;
      end
      @(posedge clk); #1;
      budget++;
    end
    en = 0; req = 0;
    if (n < 32) tmo = 1;
    if (done !== 1'b1 || rdy !== 1'b0 || cyc !== 1'b0) done_ok = 0;
    @(posedge clk); #1;
    if (done !== 1'b0 || cyc !== 1'b0) done_ok = 0;
    flags = {cyc_ok, rdy_ok, done_ok, early, tmo};
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cyc, rdy, q, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got cyc/rdy/q/done=%b expected 0000", {cyc, rdy, q, done});
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic check_load(input string name, input logic [31:0] word, input logic [4:0] flags);
    logic [31:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hXXXXXXXX;
    checks++;
    if (word !== exp) begin
      errors++;
      $display("FAIL %s_data got %08h expected %08h", name, word, exp);
    end
    checks++;
    if (flags !== 5'b11100) begin
      errors++;
      $display("FAIL %s_handshake got flags %b expected 11100", name, flags);
    end
  endtask

  task automatic test_word();
    logic [31:0] w; logic [4:0] f;
    run_load(32'hDEADBEEF, 2'd0, 2'd2, 1'b0, 0, 0, 0, w, f);
    check_load("word", w, f);
    run_load(32'h89ABCDEF, 2'd0, 2'd3, 1'b1, 0, 0, 0, w, f);
    check_load("size3_word", w, f);
  endtask

  task automatic test_byte();
    logic [31:0] w; logic [4:0] f;
    run_load(32'h12F45678, 2'd2, 2'd0, 1'b1, 0, 0, 0, w, f);
    check_load("byte_signed", w, f);
    run_load(32'h12F45678, 2'd2, 2'd0, 1'b0, 0, 0, 0, w, f);
    check_load("byte_unsigned", w, f);
  endtask

  task automatic test_half();
    logic [31:0] w; logic [4:0] f;
    run_load(32'h80010000, 2'd2, 2'd1, 1'b1, 0, 0, 0, w, f);
    check_load("half_signed", w, f);
    run_load(32'h80010000, 2'd2, 2'd1, 1'b0, 0, 0, 0, w, f);
    check_load("half_unsigned", w, f);
    run_load(32'h8F00FF00, 2'd3, 2'd1, 1'b1, 0, 0, 0, w, f);
    check_load("half_misaligned", w, f);
  endtask

  task automatic test_delayed_ack();
    logic [31:0] w; logic [4:0] f; bit stray;
    stray = 0;
    ack = 1; rdt = 32'hFFFFFFFF;
    repeat (3) begin
      @(posedge clk); #1;
      if (cyc !== 1'b0 || rdy !== 1'b0) stray = 1;
    end
    ack = 0;
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL idle_ack got cyc=%b rdy=%b expected 0 0", cyc, rdy);
    end
    run_load(32'h7F00AA55, 2'd1, 2'd0, 1'b1, 5, 0, 1, w, f);
    check_load("delayed_ack", w, f);
    stray = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (cyc !== 1'b0 || rdy !== 1'b0 || done !== 1'b0) stray = 1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL no_queued_req got cyc=%b rdy=%b done=%b expected 0 0 0", cyc, rdy, done);
    end
  endtask

  task automatic test_random_en();
    logic [31:0] w, r; logic [4:0] f;
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      run_load(r, 2'(i), 2'(i), 1'b1, i, 1, 0, w, f);
      check_load("random_en", w, f);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] w; logic [4:0] f;
    req = 1; lsb = 0; size = 2'd2; sgn = 0;
    @(posedge clk); #1;
    req = 0; ack = 1; rdt = 32'hFFFFFFFF;
    @(posedge clk); #1;
    ack = 0; en = 1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({rdy, q} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_stream got rdy/q=%b expected 11", {rdy, q});
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({cyc, rdy, q, done} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_shift_reset got cyc/rdy/q/done=%b expected 0000", {cyc, rdy, q, done});
    end
    en = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    run_load(32'h80123456, 2'd3, 2'd0, 1'b1, 1, 0, 0, w, f);
    check_load("after_reset", w, f);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_delayed_ack();
    test_random_en();
    test_reset_mid_shift();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serv_rdata_ser.md
# serv_rdata_ser

Bit-serial load-data deserializer-in-reverse for the SERV core: issues a data-bus read, captures the 32-bit parallel read word, aligns it by the byte offset from the address buffer register, and streams it LSB-first, one bit per enabled cycle, into the serial datapath with byte/halfword zero- or sign-extension. It is the read-return counterpart to the serial-to-parallel address buffer. It sits between the data bus (cyc/ack/rdt) and the register-file write path.

## Interface

Parameters:
- none; data width fixed at 32, serial stream length fixed at 32 bits.

Ports:
- i_clk  in  1  core clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  start a load; sampled only in IDLE
- i_lsb  in  2  byte offset of load address (from address buffer lsb output); sampled with i_req
- i_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word; sampled with i_req
- i_signed  in  1  1 = sign-extend byte/halfword; sampled with i_req
- o_dbus_cyc  out  1  bus read request, held until ack
- i_dbus_ack  in  1  read data valid; honoured only while o_dbus_cyc=1
- i_dbus_rdt  in  32  read data, captured on ack
- o_rdy  out  1  aligned word held, stream may proceed
- i_en  in  1  shift enable, one serial bit consumed per cycle
- o_q  out  1  current serial output bit
- o_done  out  1  one-cycle pulse after 32nd bit consumed

## Operation

- States: IDLE, BUS, SHIFT.
- IDLE: i_req=1 -> latch lsb/size/signed, go BUS. i_en, i_dbus_ack ignored.
- BUS: o_dbus_cyc=1. On i_dbus_ack: data <= i_dbus_rdt >> (8*lsb) (zero fill), sign <= i_signed & (byte ? shifted[7] : half ? shifted[15] : 0), bit counter <= 0, go SHIFT.
- SHIFT: o_rdy=1. Each i_en=1: data shifts right one, counter +1 (5-bit). Counter wraps 31->0 on 32nd i_en: go IDLE, o_done pulses next cycle.
- o_q in SHIFT: data[0] while counter < limit (8 byte, 16 half, 32 word), else sign. o_q=0 outside SHIFT.
- Misaligned half/word (lsb+size beyond bit 31): no trap; result is the zero-filled shifted value, extended per above. Detection is the core's responsibility.
- i_req outside IDLE ignored; no queuing.
- i_req and i_dbus_ack in same IDLE cycle: ack ignored.

## Timing

- Reset (async assert): state IDLE; o_dbus_cyc=0, o_rdy=0, o_q=0, o_done=0, data/counter/sign=0. Reset mid-BUS drops o_dbus_cyc immediately; mid-SHIFT drops o_rdy, truncating stream.
- o_dbus_cyc rises the cycle after i_req accepted; falls the cycle after ack edge.
- o_rdy rises the cycle after ack; stays high through the cycle of the 32nd i_en; falls next cycle with o_done=1 for one cycle.
- Minimum load: 1 (req) + 1 (ack, zero wait) + 32 shift cycles; i_en gaps stall the stream without loss.
- New i_req accepted in the o_done cycle (state already IDLE).
- o_q combinational from registered state only; no i_* to o_q path.

## Structure

- Shared package/header: size encodings (BYTE=0, HALF=1, WORD=2), state encodings, stream length constant 32.
- One sub-module natural: serv_rdata_align (combinational: shift-by-lsb, sign-bit select, bit-limit compare); FSM, counter and data register stay in top.

## Test plan

- Word, lsb=0, unsigned, rdt=0xDEADBEEF, ack 0-wait -> 32 serial bits reassemble to 0xDEADBEEF; o_done one cycle after 32nd i_en.
- Byte, lsb=2, signed, rdt=0x12F45678 -> stream 0xFFFFFFF4; same unsigned -> 0x000000F4.
- Half, lsb=2, rdt=0x80010000, signed -> 0xFFFF8001; unsigned -> 0x00008001.
- Ack delayed 5 cycles, ack asserted while cyc=0 beforehand, i_req pulsed during BUS/SHIFT -> cyc held 5 cycles, spurious ack/req ignored, single result.
- i_en toggled 50% random during SHIFT -> identical bit sequence, o_done only after 32 enables.
- i_rst_n low at shift bit 10 -> all outputs 0 immediately; next load after release completes correctly.
